// File: rtl/mem_lsu_if.sv
// Data-memory bus of the load/store unit: req/gnt address phase followed by an rvalid read response.
interface mem_lsu_if #(
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
);
   logic              req;
   logic              we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: lane shifting, byte strobes, load extension,
// req/gnt/rvalid handshake with pipeline stall, misalignment and response-timeout detection.
module mem_lsu #(
   parameter int DATA_W      = 32,
   parameter int STRB_W      = DATA_W / 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              misalign_o,
   output logic              err_o,
   mem_lsu_if.master         mem
);
   localparam int OFF_W = $clog2(STRB_W);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2, DONE = 2'd3} state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = off[0];
         2'b10:   bad = (off[1:0] != 2'b00);
         2'b11:   bad = (DATA_W == 32) ? 1'b1 : (off != {OFF_W{1'b0}});
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [STRB_W-1:0] strobe(input logic [1:0] size, input logic [OFF_W-1:0] off);
      logic [STRB_W-1:0] base;
      base = {STRB_W{1'b0}};
      case (size)
         2'b00:   base[0]   = 1'b1;
         2'b01:   base[1:0] = 2'b11;
         2'b10:   base[3:0] = 4'hF;
         2'b11:   base      = {STRB_W{1'b1}};
         default: base      = {STRB_W{1'b0}};
      endcase
      return base << off;
   endfunction

   // Field width w selects the kept bits; everything above is filled with the sign (or zero).
   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw, input logic [1:0] size,
                                                input logic uns, input logic [OFF_W-1:0] off);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] keep;
      logic              sgn;
      int                w;
      sh = raw >> {off, 3'b000};
      case (size)
         2'b00:   begin w = 32'sd8;  sgn = sh[7];        end
         2'b01:   begin w = 32'sd16; sgn = sh[15];       end
         2'b10:   begin w = 32'sd32; sgn = sh[31];       end
         default: begin w = DATA_W;  sgn = sh[DATA_W-1]; end
      endcase
      keep = {DATA_W{1'b1}} >> (DATA_W - w);
      return (sh & keep) | ({DATA_W{sgn & ~uns}} & ~keep);
   endfunction

   state_e            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              we_q, we_d;
   logic              uns_q, uns_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              stall_s, misalign_s, valid_s, bad_s;
   logic [OFF_W-1:0]  off_s;

   // Gating with rst_ni keeps the combinational outputs at 0 while reset is asserted.
   assign valid_s = valid_i & rst_ni;
   assign off_s   = addr_i[OFF_W-1:0];
   assign bad_s   = is_misaligned(size_i, off_s);

   // Next-state, capture and handshake decode
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      off_d      = off_q;
      size_d     = size_q;
      we_d       = we_q;
      uns_d      = uns_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      stall_s    = 1'b0;
      misalign_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_s && bad_s) begin
               misalign_s = 1'b1;
            end else if (valid_s) begin
               stall_s = 1'b1;
               addr_d  = {addr_i[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
               wdata_d = wdata_i << {off_s, 3'b000};
               wstrb_d = we_i ? strobe(size_i, off_s) : {STRB_W{1'b0}};
               off_d   = off_s;
               size_d  = size_i;
               we_d    = we_i;
               uns_d   = unsigned_i;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (mem.gnt && we_q) begin
               state_d = DONE;
            end else if (mem.gnt) begin
               cnt_d   = 16'd0;
               state_d = WAIT_R;
            end else begin
               state_d = REQ;
            end
         end
         WAIT_R: begin
            stall_s = 1'b1;
            if (mem.rvalid) begin
               rdata_d = extend(mem.rdata, size_q, uns_q, off_q);
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = {DATA_W{1'b0}};
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and captured access registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= {DATA_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         wstrb_q <= {STRB_W{1'b0}};
         off_q   <= {OFF_W{1'b0}};
         size_q  <= 2'b00;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         cnt_q   <= 16'd0;
         rdata_q <= {DATA_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         off_q   <= off_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign stall_o    = stall_s;
   assign misalign_o = misalign_s;
   assign done_o     = (state_q == DONE);
   assign err_o      = err_q;
   assign rdata_o    = rdata_q;
   assign mem.req    = (state_q == REQ);
   assign mem.we     = we_q;
   assign mem.addr   = addr_q;
   assign mem.wdata  = wdata_q;
   assign mem.wstrb  = wstrb_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table from the test plan, randomized accesses against a
// behavioural model, and hand sequences for reset state and reset during a pending load.
module tb_mem_lsu;
   localparam int TO = 4;

   logic        clk;
   logic        rst_ni;
   logic        valid_i, we_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, done_o, misalign_o, err_o;
   logic [31:0] rdata_o;

   mem_lsu_if #(.DATA_W(32)) mem_if ();

   mem_lsu #(.DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
      .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o), .err_o(err_o), .mem(mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, wdata, rdata_mem;
      int          gnt_dly, rv_dly;
      logic        rv_gnt;
      logic        exp_mis;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_done;
   } acc_t;

   int          n_cmp, n_bad;
   logic [31:0] last_rd;
   acc_t        vec[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic acc_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rmem,
                               input int gd, input int rd, input logic rvg, input logic emis,
                               input logic [31:0] eaddr, input logic [31:0] ewdata, input logic [3:0] estrb,
                               input logic [31:0] erdata, input logic eerr, input int edone);
      acc_t a;
      a.we = we; a.size = size; a.uns = uns; a.addr = addr; a.wdata = wdata; a.rdata_mem = rmem;
      a.gnt_dly = gd; a.rv_dly = rd; a.rv_gnt = rvg; a.exp_mis = emis; a.exp_addr = eaddr;
      a.exp_wdata = ewdata; a.exp_wstrb = estrb; a.exp_rdata = erdata; a.exp_err = eerr; a.exp_done = edone;
      return a;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] raw, input logic [31:0] addr,
                                            input logic [1:0] size, input logic uns);
      logic [31:0] v;
      v = raw >> (8 * (addr % 4));
      if (size == 2'b00) begin
         v = v & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // Reference model: derives every expectation from the access description alone.
   task automatic fill(inout acc_t a);
      int          off, nbytes;
      logic [31:0] m;
      off       = int'(a.addr % 4);
      nbytes    = 1 << a.size;
      a.exp_mis = (a.size == 2'b11) || (a.addr % nbytes != 0);
      a.exp_addr  = a.addr - off;
      a.exp_wdata = a.wdata << (8 * off);
      m           = ((32'd1 << nbytes) - 32'd1) << off;
      a.exp_wstrb = a.we ? m[3:0] : 4'h0;
      a.exp_err   = 1'b0;
      a.exp_rdata = last_rd;
      a.exp_done  = 0;
      if (a.exp_mis) begin
         a.exp_done = 0;
      end else if (a.we) begin
         a.exp_done = a.gnt_dly + 2;
      end else if (a.rv_dly >= TO) begin
         a.exp_done  = a.gnt_dly + 2 + TO;
         a.exp_err   = 1'b1;
         a.exp_rdata = 32'h0;
         last_rd     = 32'h0;
      end else begin
         a.exp_done  = a.gnt_dly + 3 + a.rv_dly;
         a.exp_rdata = load_val(a.rdata_mem, a.addr, a.size, a.uns);
         last_rd     = a.exp_rdata;
      end
   endtask

   task automatic check_zero(input string t);
      chk({t, "_stall"}, stall_o, 32'h0);
      chk({t, "_done"}, done_o, 32'h0);
      chk({t, "_misalign"}, misalign_o, 32'h0);
      chk({t, "_err"}, err_o, 32'h0);
      chk({t, "_rdata"}, rdata_o, 32'h0);
      chk({t, "_req"}, mem_if.req, 32'h0);
      chk({t, "_we"}, mem_if.we, 32'h0);
      chk({t, "_addr"}, mem_if.addr, 32'h0);
      chk({t, "_wdata"}, mem_if.wdata, 32'h0);
      chk({t, "_wstrb"}, mem_if.wstrb, 32'h0);
   endtask

   // Drives one access, plays the memory side with the requested delays and checks the outcome.
   task automatic run_check(input string t, input acc_t a);
      int          req_n, wait_n, done_n, done_cyc, stall_n, c;
      logic        granted, rv_sent, req_seen, unstable, stall_done, err_s, stall0, mis0, we_s;
      logic [31:0] addr_s, wdata_s, rdata_s;
      logic [3:0]  wstrb_s;
      req_n = 0; wait_n = 0; done_n = 0; done_cyc = 0; stall_n = 0;
      granted = 1'b0; rv_sent = 1'b0; req_seen = 1'b0; unstable = 1'b0; stall_done = 1'b0;
      err_s = 1'b0; we_s = 1'b0; addr_s = 32'h0; wdata_s = 32'h0; rdata_s = 32'h0; wstrb_s = 4'h0;
      @(negedge clk);
      valid_i = 1'b1; we_i = a.we; size_i = a.size; unsigned_i = a.uns; addr_i = a.addr; wdata_i = a.wdata;
      mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = $urandom;
      #1;
      mis0 = misalign_o; stall0 = stall_o;
      if (stall_o) stall_n++;
      if (mem_if.req) req_seen = 1'b1;
      c = 0;
      while (c < 40 && !(done_n > 0 && c > done_cyc) && !(mis0 && c >= 3)) begin
         c++;
         @(negedge clk);
         if (done_n > 0 || mis0) valid_i = 1'b0;
         mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = $urandom;
         if (granted && !rv_sent) begin
            if (wait_n == a.rv_dly) begin
               mem_if.rvalid = 1'b1; mem_if.rdata = a.rdata_mem; rv_sent = 1'b1;
            end
            wait_n++;
         end
         if (mem_if.req) begin
            if (!req_seen) begin
               req_seen = 1'b1; addr_s = mem_if.addr; wdata_s = mem_if.wdata;
               wstrb_s = mem_if.wstrb; we_s = mem_if.we;
            end else if (mem_if.addr !== addr_s || mem_if.wdata !== wdata_s ||
                         mem_if.wstrb !== wstrb_s || mem_if.we !== we_s) begin
               unstable = 1'b1;
            end
            if (!granted && req_n == a.gnt_dly) begin
               mem_if.gnt = 1'b1; granted = 1'b1;
               if (a.rv_gnt) mem_if.rvalid = 1'b1;
            end
            req_n++;
         end
         #1;
         if (stall_o) stall_n++;
         if (done_o) begin
            done_n++;
            if (done_n == 1) begin
               done_cyc = c; rdata_s = rdata_o; err_s = err_o; stall_done = stall_o;
            end
         end
      end
      valid_i = 1'b0;
      chk({t, "_misalign"}, mis0, a.exp_mis);
      if (a.exp_mis) begin
         chk({t, "_mis_stall"}, stall0, 32'h0);
         chk({t, "_mis_req"}, req_seen, 32'h0);
         chk({t, "_mis_done"}, done_n, 32'h0);
      end else begin
         chk({t, "_stall0"}, stall0, 32'h1);
         chk({t, "_done_count"}, done_n, 32'h1);
         chk({t, "_done_cycle"}, done_cyc, a.exp_done);
         chk({t, "_stall_cycles"}, stall_n, a.exp_done);
         chk({t, "_stall_at_done"}, stall_done, 32'h0);
         chk({t, "_err"}, err_s, a.exp_err);
         chk({t, "_rdata"}, rdata_s, a.exp_rdata);
         chk({t, "_addr"}, addr_s, a.exp_addr);
         chk({t, "_we"}, we_s, a.we);
         chk({t, "_wstrb"}, wstrb_s, a.exp_wstrb);
         chk({t, "_wdata"}, wdata_s, a.exp_wdata);
         chk({t, "_stable"}, unstable, 32'h0);
      end
   endtask

   initial begin
      acc_t a;
      logic seen;
      n_cmp = 0; n_bad = 0; last_rd = 32'h0;
      rst_ni = 1'b0; valid_i = 1'b1; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = 32'h103; wdata_i = 32'h0;
      mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1 check_zero("reset");
      @(negedge clk);
      rst_ni = 1'b1; valid_i = 1'b0;

      vec.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0,
                       1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2));
      vec.push_back(mk(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0,
                       1'b0, 32'h100, 32'hA5000000, 4'h8, 32'h0, 1'b0, 2));
      vec.push_back(mk(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h123480FF, 0, 0, 1'b0,
                       1'b0, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80, 1'b0, 3));
      vec.push_back(mk(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h123480FF, 0, 0, 1'b0,
                       1'b0, 32'h100, 32'h0, 4'h0, 32'h00000080, 1'b0, 3));
      vec.push_back(mk(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h123480FF, 0, 0, 1'b0,
                       1'b0, 32'h100, 32'h0, 4'h0, 32'h00001234, 1'b0, 3));
      vec.push_back(mk(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0,
                       1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 0));
      vec.push_back(mk(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 3, 2, 1'b0,
                       1'b0, 32'h200, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 8));
      vec.push_back(mk(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h5555AAAA, 0, 9, 1'b0,
                       1'b0, 32'h300, 32'h0, 4'h0, 32'h0, 1'b1, 6));
      vec.push_back(mk(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 32'h87654321, 1, 1, 1'b1,
                       1'b0, 32'h104, 32'h0, 4'h0, 32'hFFFF8765, 1'b0, 5));
      vec.push_back(mk(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 32'h0, 2, 0, 1'b0,
                       1'b0, 32'h100, 32'hBEEF0000, 4'hC, 32'hFFFF8765, 1'b0, 4));
      vec.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0, 32'h11111111, 32'h0, 0, 0, 1'b0,
                       1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 0));
      foreach (vec[i]) run_check($sformatf("vec%0d", i), vec[i]);
      last_rd = 32'hFFFF8765;

      for (int i = 0; i < 60; i++) begin
         a.we = 1'($urandom_range(0, 1));
         a.size = 2'($urandom_range(0, 3));
         a.uns = 1'($urandom_range(0, 1));
         a.addr = $urandom;
         if ($urandom_range(0, 3) != 0) a.addr = a.addr - (a.addr % (1 << a.size));
         a.wdata = $urandom; a.rdata_mem = $urandom;
         a.gnt_dly = $urandom_range(0, 3); a.rv_dly = $urandom_range(0, 5);
         a.rv_gnt = 1'($urandom_range(0, 1));
         fill(a);
         run_check($sformatf("rnd%0d", i), a);
      end

      @(negedge clk);
      valid_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
      addr_i = 32'h400; wdata_i = 32'h12345678;
      @(negedge clk);
      mem_if.gnt = 1'b1;
      @(negedge clk);
      mem_if.gnt = 1'b0;
      #1;
      chk("rstwait_stall", stall_o, 32'h1);
      chk("rstwait_req", mem_if.req, 32'h0);
      rst_ni = 1'b0; valid_i = 1'b0;
      #1 check_zero("rst_mid");
      @(negedge clk);
      rst_ni = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1 if (done_o || stall_o || mem_if.req) seen = 1'b1;
      end
      chk("rst_no_done", seen, 32'h0);
      last_rd = 32'h0;

      a.we = 1'b1; a.size = 2'b10; a.uns = 1'b0; a.addr = 32'h40; a.wdata = 32'h0BADF00D;
      a.rdata_mem = 32'h0; a.gnt_dly = 1; a.rv_dly = 0; a.rv_gnt = 1'b0;
      fill(a);
      run_check("post_rst_sw", a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
